multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high: clk_i and rst_i.
REQ-002 Ports SHALL be, one per line:
  clk_i  in  1  rising-edge clock
  rst_i  in  1  synchronous active-high reset
  opcode_i  in  6  instruction[31:26], stable from the cycle after FETCH completes
  mem_ready_i  in  1  memory handshake, access completes on the cycle it is high
  pc_write_o  out  1  unconditional PC load
  pc_write_cond_o  out  1  PC load if ALU zero (beq)
  iord_o  out  1  memory address select: 0 = PC, 1 = ALUOut
  mem_read_o  out  1  memory read request
  mem_write_o  out  1  memory write request
  ir_write_o  out  1  instruction register load
  reg_dst_o  out  1  write register select: 0 = rt, 1 = rd
  mem_to_reg_o  out  1  writeback select: 0 = ALUOut, 1 = MDR
  reg_write_o  out  1  register file write enable
  alu_src_a_o  out  1  0 = PC, 1 = register A
  alu_src_b_o  out  2  00 = B, 01 = const 4, 10 = ext imm, 11 = ext imm shifted left 2
  alu_op_o  out  2  00 = add, 01 = sub, 10 = funct decode, 11 = opcode decode
  pc_src_o  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
  ext_zero_o  out  1  immediate extender mode: 1 = zero-extend, 0 = sign-extend
  illegal_o  out  1  one-cycle pulse on an unsupported opcode
  state_o  out  4  current state, for debug

Function
REQ-003 The controller SHALL be a Moore FSM. The only exceptions are ir_write_o and pc_write_o in FETCH, which SHALL be gated by mem_ready_i.
REQ-004 State encodings SHALL be: IDLE = 0, FETCH = 1, DECODE = 2, MEM_ADDR = 3, MEM_RD = 4, MEM_WB = 5, MEM_WR = 6, EXEC_R = 7, R_WB = 8, BRANCH = 9, JUMP = 10, EXEC_I = 11, I_WB = 12. Encodings 13-15 SHALL go to FETCH.
REQ-005 Transitions:
  IDLE → FETCH.
  FETCH holds while mem_ready_i = 0, else → DECODE.
  DECODE, by opcode:
    000000 → EXEC_R
    100011 / 101011 → MEM_ADDR
    000100 → BRANCH
    000010 → JUMP
    001000 / 001010 / 001100 / 001101 → EXEC_I
    any other → FETCH, with illegal_o = 1 for that cycle.
  MEM_ADDR → MEM_RD (lw) or MEM_WR (sw).
  MEM_RD holds until mem_ready_i, then → MEM_WB.
  MEM_WR holds until mem_ready_i, then → FETCH.
  EXEC_R → R_WB.  EXEC_I → I_WB.
  MEM_WB, R_WB, I_WB, BRANCH, JUMP → FETCH.
REQ-006 Asserted outputs per state; every output not listed SHALL be 0:
  FETCH: mem_read, alu_src_b = 01, ir_write and pc_write qualified by mem_ready_i.
  DECODE: alu_src_b = 11.
  MEM_ADDR: alu_src_a, alu_src_b = 10.
  MEM_RD: mem_read, iord.
  MEM_WR: mem_write, iord.
  MEM_WB: mem_to_reg, reg_write.
  EXEC_R: alu_src_a, alu_op = 10.
  R_WB: reg_dst, reg_write.
  BRANCH: alu_src_a, alu_op = 01, pc_write_cond, pc_src = 01.
  JUMP: pc_write, pc_src = 10.
  EXEC_I: alu_src_a, alu_src_b = 10, alu_op = 11, ext_zero = 1 iff opcode is 001100 or 001101.
  I_WB: reg_write.
REQ-007 ext_zero_o SHALL be 0 in every state except EXEC_I; lw/sw offsets and beq offsets are therefore sign-extended.
REQ-008 Instruction latency with mem_ready_i tied high SHALL be:
  lw 5 cycles; sw, R-type and I-type 4 cycles; beq and j 3 cycles.
  Each wait cycle SHALL add exactly one cycle.
REQ-009 mem_read_o and mem_write_o SHALL never be high in the same cycle.
REQ-010 mem_ready_i SHALL be ignored outside FETCH, MEM_RD and MEM_WR.

Reset
REQ-011 When rst_i is sampled high, the state SHALL become IDLE on that edge, and all outputs SHALL be 0 and state_o = 0 in the following cycle.
REQ-012 A reset asserted during any state, including an outstanding MEM_RD/MEM_WR wait, SHALL abandon the instruction without any further write strobe.

Structure
REQ-013 A shared package SHALL hold:
  the state enum;
  opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI;
  the alu_op, alu_src_b and pc_src encodings.
REQ-014 The block SHALL be one module with a state register, a next-state process and an output decode. No sub-module is required; the ALU-control decoder remains a separate existing block.

Verification
REQ-015 Reset, then lw (opcode 100011) with mem_ready_i always high → states 1, 2, 3, 4, 5, 1; reg_write_o and mem_to_reg_o high only in MEM_WB.
REQ-016 sw with mem_ready_i low for 3 cycles in MEM_WR → MEM_WR held 4 cycles; mem_write_o high in all 4; return to FETCH.
REQ-017 ori (001101) → ext_zero_o = 1 only in EXEC_I. addi (001000) → ext_zero_o = 0 throughout.
REQ-018 beq → BRANCH with pc_write_cond_o = 1 and pc_src_o = 01; j → JUMP with pc_write_o = 1 and pc_src_o = 10; both return to FETCH.
REQ-019 Opcode 111111 → illegal_o high for exactly one cycle, then FETCH; no write strobe asserted.
REQ-020 rst_i raised in MEM_RD while mem_ready_i = 0 → IDLE next cycle with all outputs 0, then FETCH.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared state, opcode and datapath-select encodings
// Imported by the multicycle controller and anything decoding its debug state.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_EXEC_I   = 4'd11,
    S_I_WB     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OPC   = 2'b11;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_4       = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_imm_op(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore control FSM for a multicycle MIPS-style datapath
// Only FETCH's ir_write/pc_write follow mem_ready_i combinationally.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_src_o,
  output logic       ext_zero_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  state_e r_state;
  state_e w_next;
  logic   w_legal;

  assign w_legal = (opcode_i == OP_RTYPE) || (opcode_i == OP_LW) || (opcode_i == OP_SW) ||
                   (opcode_i == OP_BEQ) || (opcode_i == OP_J) || is_imm_op(opcode_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_IDLE:     w_next = S_FETCH;
      S_FETCH:    w_next = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode_i == OP_RTYPE)                         w_next = S_EXEC_R;
        else if ((opcode_i == OP_LW) || (opcode_i == OP_SW)) w_next = S_MEM_ADDR;
        else if (opcode_i == OP_BEQ)                      w_next = S_BRANCH;
        else if (opcode_i == OP_J)                        w_next = S_JUMP;
        else if (is_imm_op(opcode_i))                     w_next = S_EXEC_I;
        else                                              w_next = S_FETCH;
      end
      S_MEM_ADDR: w_next = (opcode_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   w_next = mem_ready_i ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   w_next = mem_ready_i ? S_FETCH : S_MEM_WR;
      S_EXEC_R:   w_next = S_R_WB;
      S_EXEC_I:   w_next = S_I_WB;
      default:    w_next = S_FETCH;
    endcase
  end

  // Output decode; unlisted states (IDLE, out-of-range codes) drive all zeros.
  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    iord_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = SRCB_B;
    alu_op_o        = ALU_ADD;
    pc_src_o        = PCSRC_ALU;
    ext_zero_o      = 1'b0;
    illegal_o       = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_4;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_b_o = SRCB_IMM_SH2;
        illegal_o   = ~w_legal;
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
      end
      S_MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
      end
      S_MEM_WB: begin
        mem_to_reg_o = 1'b1;
        reg_write_o  = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_FUNCT;
      end
      S_R_WB: begin
        reg_dst_o   = 1'b1;
        reg_write_o = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = ALU_SUB;
        pc_write_cond_o = 1'b1;
        pc_src_o        = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = PCSRC_JUMP;
      end
      S_EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = ALU_OPC;
        ext_zero_o  = (opcode_i == OP_ANDI) || (opcode_i == OP_ORI);
      end
      S_I_WB:  reg_write_o = 1'b1;
      default: ;
    endcase
  end

  assign state_o = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
// Instruction-level model expands each instruction into expected per-cycle records.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [5:0] opcode_i;
  logic       mem_ready_i;
  logic       pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o, ir_write_o;
  logic       reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, ext_zero_o, illegal_o;
  logic [1:0] alu_src_b_o, alu_op_o, pc_src_o;
  logic [3:0] state_o;

  multicycle_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .iord_o(iord_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .ir_write_o(ir_write_o),
    .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .pc_src_o(pc_src_o), .ext_zero_o(ext_zero_o), .illegal_o(illegal_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       ext_zero, illegal;
  } outs_t;

  typedef struct { logic [5:0] op; logic rdy; logic rst; } stim_t;
  typedef struct { logic [3:0] st; outs_t o; } exp_t;

  outs_t act;
  assign act = {pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o, ir_write_o,
                reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o,
                pc_src_o, ext_zero_o, illegal_o};

  stim_t sq[$];
  exp_t  eq[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  bit    running = 1'b0;

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08, 6'h0a, 6'h0c, 6'h0d};
  endfunction

  // Expected strobes per state, written straight from the state/output table.
  function automatic outs_t exp_outs(input int st, input logic [5:0] op, input logic rdy);
    outs_t o;
    o = '0;
    case (st)
      1:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
      2:  begin o.alu_src_b = 2'b11; o.illegal = !legal(op); end
      3:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      4:  begin o.mem_read = 1; o.iord = 1; end
      5:  begin o.mem_to_reg = 1; o.reg_write = 1; end
      6:  begin o.mem_write = 1; o.iord = 1; end
      7:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
      8:  begin o.reg_dst = 1; o.reg_write = 1; end
      9:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_src = 2'b01; end
      10: begin o.pc_write = 1; o.pc_src = 2'b10; end
      11: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 2'b11;
                o.ext_zero = (op == 6'h0c) || (op == 6'h0d); end
      12: o.reg_write = 1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic add_cyc(input int st, input logic [5:0] op, input logic rdy, input logic rst = 1'b0);
    stim_t s;
    exp_t  e;
    s.op = op; s.rdy = rdy; s.rst = rst;
    sq.push_back(s);
    e.st = 4'(st);
    e.o  = exp_outs(st, op, rdy);
    eq.push_back(e);
  endtask

  // One instruction: fw fetch waits, mw memory waits, abort = reset during a lw wait.
  task automatic gen(input logic [5:0] op, input int fw, input int mw, input bit abort);
    for (int i = 0; i < fw; i++) add_cyc(1, 6'($urandom_range(0, 63)), 1'b0);
    add_cyc(1, 6'($urandom_range(0, 63)), 1'b1);
    add_cyc(2, op, rb());
    if (!legal(op)) return;
    case (op)
      6'h23: begin
        add_cyc(3, op, rb());
        if (abort) begin
          add_cyc(4, op, 1'b0, 1'b1);
          add_cyc(0, 6'($urandom_range(0, 63)), rb());
          return;
        end
        for (int i = 0; i < mw; i++) add_cyc(4, op, 1'b0);
        add_cyc(4, op, 1'b1);
        add_cyc(5, op, rb());
      end
      6'h2b: begin
        add_cyc(3, op, rb());
        for (int i = 0; i < mw; i++) add_cyc(6, op, 1'b0);
        add_cyc(6, op, 1'b1);
      end
      6'h00: begin add_cyc(7, op, rb()); add_cyc(8, op, rb()); end
      6'h04: add_cyc(9, op, rb());
      6'h02: add_cyc(10, op, rb());
      default: begin add_cyc(11, op, rb()); add_cyc(12, op, rb()); end
    endcase
  endtask

  task automatic run();
    stim_t s;
    while (sq.size() > 0) begin
      @(posedge clk);
      #1;
      s = sq.pop_front();
      rst_i = s.rst;
      opcode_i = s.op;
      mem_ready_i = s.rdy;
      running = 1'b1;
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (running) begin
        cyc++;
        total++;
        if (mem_read_o && mem_write_o) begin
          bad++;
          $display("FAIL rd_wr_exclusive cyc=%0d got both high, required at most one", cyc);
        end
        total++;
        if (eq.size() == 0) begin
          bad++;
          $display("FAIL scoreboard_underflow cyc=%0d got DUT cycle, required an expected record", cyc);
        end else begin
          e = eq.pop_front();
          if (state_o !== e.st) begin
            bad++;
            $display("FAIL state cyc=%0d got=%0d required=%0d", cyc, state_o, e.st);
          end
          total++;
          if (act !== e.o) begin
            bad++;
            $display("FAIL outputs cyc=%0d state=%0d got=%h required=%h", cyc, e.st, act, e.o);
          end
        end
      end
    end
  end

  initial begin
    logic [5:0] ops [11];
    logic [5:0] op;
    ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h3f, 6'h11};
    rst_i = 1'b1; opcode_i = '0; mem_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (state_o !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d required=0", state_o); end
    total++;
    if (act !== '0) begin bad++; $display("FAIL reset_outputs got=%h required=0", act); end

    add_cyc(0, 6'h00, rb());
    gen(6'h23, 0, 0, 1'b0);
    gen(6'h2b, 0, 3, 1'b0);
    gen(6'h0d, 0, 0, 1'b0);
    gen(6'h08, 1, 0, 1'b0);
    gen(6'h04, 0, 0, 1'b0);
    gen(6'h02, 2, 0, 1'b0);
    gen(6'h3f, 0, 0, 1'b0);
    gen(6'h23, 0, 2, 1'b1);
    gen(6'h00, 0, 0, 1'b0);
    run();
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) op = 6'($urandom_range(0, 63));
      else                           op = ops[$urandom_range(0, 10)];
      gen(op, $urandom_range(0, 2), $urandom_range(0, 3), (op == 6'h23) && ($urandom_range(0, 3) == 0));
      run();
    end
    @(negedge clk);
    #1;
    running = 1'b0;
    total++;
    if (eq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d left required=0", eq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
